// File: rtl/apb_slave_mem.sv
// APB slave backed by a register-file memory with a configurable number of wait states.
// Registered PREADY/PRDATA/PSLVERR; every storage word returns to zero on reset.
module apb_slave_mem #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH       = 64,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                  pclk_i,
    input  logic                  prst_i,
    input  logic                  psel_i,
    input  logic                  penable_i,
    input  logic                  pwrite_i,
    input  logic [ADDR_WIDTH-1:0] paddr_i,
    input  logic [DATA_WIDTH-1:0] pwdata_i,
    output logic                  pready_o,
    output logic [DATA_WIDTH-1:0] prdata_o,
    output logic                  pslverr_o
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_READY = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  write_q, write_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  pready_q, pready_d;
    logic                  pslverr_q, pslverr_d;
    logic [DATA_WIDTH-1:0] prdata_q, prdata_d;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic                  into_ready;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] tgt_addr;
    logic                  tgt_write;
    logic                  tgt_in_range;
    logic [IDX_W-1:0]      tgt_idx;
    logic [DATA_WIDTH-1:0] rd_word;

    // With zero wait states the setup edge is also the edge into READY, so the
    // response must be built from the live bus rather than the latched copy.
    always_comb begin
        tgt_addr     = (state_q == ST_IDLE) ? paddr_i : addr_q;
        tgt_write    = (state_q == ST_IDLE) ? pwrite_i : write_q;
        tgt_in_range = (tgt_addr < ADDR_WIDTH'(DEPTH));
        tgt_idx      = tgt_addr[IDX_W-1:0];
        rd_word      = mem_q[tgt_idx];
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        write_d    = write_q;
        wdata_d    = wdata_q;
        into_ready = 1'b0;
        mem_we     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (psel_i && !penable_i) begin
                    addr_d  = paddr_i;
                    write_d = pwrite_i;
                    wdata_d = pwdata_i;
                    cnt_d   = '0;
                    if (WAIT_CYCLES == 0) begin
                        state_d    = ST_READY;
                        into_ready = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (!psel_i) begin
                    state_d = ST_IDLE;
                end else if (penable_i) begin
                    if (cnt_q == CNT_LAST) begin
                        state_d    = ST_READY;
                        into_ready = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_READY: begin
                state_d = ST_IDLE;
                mem_we  = psel_i && penable_i && write_q && tgt_in_range;
            end
            default: state_d = ST_IDLE;
        endcase

        // READY lasts a single cycle, so the response is non-zero only on entry.
        pready_d  = into_ready;
        pslverr_d = into_ready && !tgt_in_range;
        prdata_d  = (into_ready && !tgt_write && tgt_in_range) ? rd_word : '0;
    end

    always_ff @(posedge pclk_i) begin
        if (prst_i) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            write_q   <= 1'b0;
            wdata_q   <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            write_q   <= write_d;
            wdata_q   <= wdata_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
            prdata_q  <= prdata_d;
        end
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_word
            always_ff @(posedge pclk_i) begin
                if (prst_i) begin
                    mem_q[gi] <= '0;
                end else if (mem_we && (tgt_idx == IDX_W'(gi))) begin
                    mem_q[gi] <= wdata_q;
                end
            end
        end
    endgenerate

    assign pready_o  = pready_q;
    assign pslverr_o = pslverr_q;
    assign prdata_o  = prdata_q;

endmodule

// File: tb/tb_apb_slave_mem.sv
// Randomised APB bench for apb_slave_mem: a 2-wait-state instance and a zero-wait instance
// checked against an array model of the memory and the APB response rules.
module tb_apb_slave_mem;

    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int DEPTH = 64;
    localparam int WC    = 2;

    logic          clk = 1'b0;
    logic          prst;
    logic          psel_a, psel_b, penable, pwrite;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pwdata;
    logic          pready_a, pslverr_a, pready_b, pslverr_b;
    logic [DW-1:0] prdata_a, prdata_b;

    always #5 clk = ~clk;

    apb_slave_mem #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .WAIT_CYCLES(WC)) dut_a (
        .pclk_i(clk), .prst_i(prst), .psel_i(psel_a), .penable_i(penable), .pwrite_i(pwrite),
        .paddr_i(paddr), .pwdata_i(pwdata), .pready_o(pready_a), .prdata_o(prdata_a),
        .pslverr_o(pslverr_a)
    );

    apb_slave_mem #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .WAIT_CYCLES(0)) dut_b (
        .pclk_i(clk), .prst_i(prst), .psel_i(psel_b), .penable_i(penable), .pwrite_i(pwrite),
        .paddr_i(paddr), .pwdata_i(pwdata), .pready_o(pready_b), .prdata_o(prdata_b),
        .pslverr_o(pslverr_b)
    );

    typedef struct {
        int          waits;
        logic [31:0] rdata;
        logic        err;
        bit          cleared;
    } obs_t;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] ref_a [DEPTH];
    logic [31:0] ref_b [DEPTH];

    function automatic void model_clear();
        for (int i = 0; i < DEPTH; i++) begin
            ref_a[i] = '0;
            ref_b[i] = '0;
        end
    endfunction

    // Expected read data: stored word for an in-range read, zero otherwise.
    function automatic logic [31:0] model_rdata(input bit fast, input bit wr, input logic [31:0] addr);
        if (wr || addr >= DEPTH) return '0;
        return fast ? ref_b[addr[5:0]] : ref_a[addr[5:0]];
    endfunction

    function automatic void model_commit(input bit fast, input bit wr, input logic [31:0] addr,
                                         input logic [31:0] data);
        if (wr && addr < DEPTH) begin
            if (fast) ref_b[addr[5:0]] = data;
            else      ref_a[addr[5:0]] = data;
        end
    endfunction

    // One APB transfer; starts right away so consecutive calls are back-to-back.
    task automatic apb_xfer(input bit fast, input bit wr, input logic [31:0] addr,
                            input logic [31:0] data, input bit scramble, output obs_t o);
        o.waits   = 0;
        o.rdata   = 'x;
        o.err     = 1'bx;
        o.cleared = 1'b0;
        if (fast) psel_b = 1'b1; else psel_a = 1'b1;
        penable = 1'b0;
        pwrite  = wr;
        paddr   = addr;
        pwdata  = data;
        @(posedge clk); #1;
        penable = 1'b1;
        if (scramble) begin
            pwrite = ~wr;
            paddr  = $urandom;
            pwdata = $urandom;
        end
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if ((fast ? pready_b : pready_a) === 1'b1) begin
                o.rdata = fast ? prdata_b : prdata_a;
                o.err   = fast ? pslverr_b : pslverr_a;
                break;
            end
            o.waits++;
        end
        @(posedge clk); #1;
        o.cleared = fast ? (pready_b === 1'b0 && pslverr_b === 1'b0 && prdata_b === '0)
                         : (pready_a === 1'b0 && pslverr_a === 1'b0 && prdata_a === '0);
        psel_a  = 1'b0;
        psel_b  = 1'b0;
        penable = 1'b0;
        $display("xfer dut=%s wr=%0d addr=%0d data=%h scr=%0d waits=%0d rdata=%h err=%0d cleared=%0d",
                 fast ? "b" : "a", wr, addr, data, scramble, o.waits, o.rdata, o.err, o.cleared);
    endtask

    task automatic test_reset();
        prst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (pready_a !== 1'b0) begin errors++; $display("FAIL reset_pready: got %b want 0", pready_a); end
        checks++;
        if (pslverr_a !== 1'b0) begin errors++; $display("FAIL reset_pslverr: got %b want 0", pslverr_a); end
        checks++;
        if (prdata_a !== '0) begin errors++; $display("FAIL reset_prdata: got %h want 0", prdata_a); end
        checks++;
        if (pready_b !== 1'b0 || prdata_b !== '0) begin
            errors++; $display("FAIL reset_fast: got pready=%b prdata=%h want 0/0", pready_b, prdata_b);
        end
        prst = 1'b0;
        model_clear();
    endtask

    task automatic test_read_unwritten();
        obs_t o;
        apb_xfer(1'b0, 1'b0, 32'd7, 32'h0, 1'b0, o);
        checks++;
        if (o.rdata !== 32'h0 || o.err !== 1'b0) begin
            errors++; $display("FAIL unwritten_read: got rdata=%h err=%b want 0/0", o.rdata, o.err);
        end
    endtask

    task automatic test_ignore_penable();
        psel_a  = 1'b1;
        penable = 1'b1;
        pwrite  = 1'b0;
        paddr   = 32'd99;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++;
            if (pready_a !== 1'b0 || pslverr_a !== 1'b0) begin
                errors++; $display("FAIL stray_penable: got pready=%b pslverr=%b want 0/0", pready_a, pslverr_a);
            end
        end
        psel_a  = 1'b0;
        penable = 1'b0;
    endtask

    task automatic test_write_read();
        obs_t o;
        apb_xfer(1'b0, 1'b1, 32'd10, 32'd20, 1'b0, o);
        model_commit(1'b0, 1'b1, 32'd10, 32'd20);
        checks++;
        if (o.waits !== WC) begin errors++; $display("FAIL wr_waits: got %0d want %0d", o.waits, WC); end
        apb_xfer(1'b0, 1'b0, 32'd10, 32'h0, 1'b0, o);
        checks++;
        if (o.waits !== WC) begin errors++; $display("FAIL rd_waits: got %0d want %0d", o.waits, WC); end
        checks++;
        if (!o.cleared) begin errors++; $display("FAIL rd_ready_one_cycle: outputs not cleared, want cleared"); end
        checks++;
        if (o.rdata !== 32'd20 || o.err !== 1'b0) begin
            errors++; $display("FAIL rd_10: got rdata=%0d err=%b want 20/0", o.rdata, o.err);
        end
    endtask

    task automatic test_back_to_back();
        obs_t        o;
        logic [31:0] exp;
        for (int i = 1; i <= 6; i++) begin
            bit          wr   = (i <= 3);
            logic [31:0] addr = 32'(10 * ((i - 1) % 3 + 1));
            logic [31:0] data = 2 * addr;
            exp = model_rdata(1'b0, wr, addr);
            apb_xfer(1'b0, wr, addr, data, 1'b0, o);
            model_commit(1'b0, wr, addr, data);
            checks++;
            if (o.waits !== WC || !o.cleared) begin
                errors++; $display("FAIL b2b_handshake[%0d]: got waits=%0d cleared=%0d want %0d/1", i, o.waits, o.cleared, WC);
            end
            checks++;
            if (o.rdata !== exp || o.err !== 1'b0) begin
                errors++; $display("FAIL b2b_data[%0d]: got rdata=%0d err=%b want %0d/0", i, o.rdata, o.err, exp);
            end
        end
    endtask

    task automatic test_out_of_range();
        obs_t        o;
        logic [31:0] probe [5];
        logic [31:0] exp;
        probe = '{32'd36, 32'd0, 32'd10, 32'd63, 32'd4};
        apb_xfer(1'b0, 1'b0, 32'd64, 32'h0, 1'b0, o);
        checks++;
        if (o.err !== 1'b1 || o.rdata !== '0 || o.waits !== WC) begin
            errors++; $display("FAIL oor_read: got err=%b rdata=%h waits=%0d want 1/0/%0d", o.err, o.rdata, o.waits, WC);
        end
        apb_xfer(1'b0, 1'b1, 32'd100, 32'hDEAD, 1'b0, o);
        model_commit(1'b0, 1'b1, 32'd100, 32'hDEAD);
        checks++;
        if (o.err !== 1'b1 || o.rdata !== '0) begin
            errors++; $display("FAIL oor_write: got err=%b rdata=%h want 1/0", o.err, o.rdata);
        end
        for (int i = 0; i < 5; i++) begin
            exp = model_rdata(1'b0, 1'b0, probe[i]);
            apb_xfer(1'b0, 1'b0, probe[i], 32'h0, 1'b0, o);
            checks++;
            if (o.rdata !== exp) begin
                errors++; $display("FAIL oor_storage[%0d]: got %h want %h", probe[i], o.rdata, exp);
            end
        end
    endtask

    task automatic test_abort();
        obs_t        o;
        logic [31:0] exp;
        psel_a  = 1'b1;
        penable = 1'b0;
        pwrite  = 1'b1;
        paddr   = 32'd3;
        pwdata  = 32'h1234_5678;
        @(posedge clk); #1;
        penable = 1'b1;
        @(posedge clk); #1;
        psel_a  = 1'b0;
        penable = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (pready_a !== 1'b0 || pslverr_a !== 1'b0) begin
            errors++; $display("FAIL abort_outputs: got pready=%b pslverr=%b want 0/0", pready_a, pslverr_a);
        end
        exp = model_rdata(1'b0, 1'b0, 32'd3);
        apb_xfer(1'b0, 1'b0, 32'd3, 32'h0, 1'b0, o);
        checks++;
        if (o.rdata !== exp) begin errors++; $display("FAIL abort_no_commit: got %h want %h", o.rdata, exp); end
    endtask

    task automatic test_fast();
        obs_t o;
        apb_xfer(1'b1, 1'b1, 32'd5, 32'hCAFE_0005, 1'b0, o);
        model_commit(1'b1, 1'b1, 32'd5, 32'hCAFE_0005);
        checks++;
        if (o.waits !== 0) begin errors++; $display("FAIL fast_wr_waits: got %0d want 0", o.waits); end
        apb_xfer(1'b1, 1'b0, 32'd5, 32'h0, 1'b0, o);
        checks++;
        if (o.waits !== 0 || !o.cleared) begin
            errors++; $display("FAIL fast_rd_handshake: got waits=%0d cleared=%0d want 0/1", o.waits, o.cleared);
        end
        checks++;
        if (o.rdata !== 32'hCAFE_0005 || o.err !== 1'b0) begin
            errors++; $display("FAIL fast_rd_data: got %h err=%b want cafe0005/0", o.rdata, o.err);
        end
    endtask

    task automatic test_random();
        obs_t        o;
        logic [31:0] exp;
        for (int i = 0; i < 40; i++) begin
            bit          fast = ($urandom_range(0, 3) == 0);
            bit          wr   = 1'($urandom_range(0, 1));
            bit          scr  = 1'($urandom_range(0, 1));
            logic [31:0] addr = 32'($urandom_range(0, 79));
            logic [31:0] data = $urandom;
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
            end
            exp = model_rdata(fast, wr, addr);
            apb_xfer(fast, wr, addr, data, scr, o);
            model_commit(fast, wr, addr, data);
            checks++;
            if (o.waits !== (fast ? 0 : WC) || !o.cleared) begin
                errors++; $display("FAIL rand_handshake[%0d]: got waits=%0d cleared=%0d want %0d/1", i, o.waits, o.cleared, fast ? 0 : WC);
            end
            checks++;
            if (o.rdata !== exp || o.err !== (addr >= DEPTH)) begin
                errors++; $display("FAIL rand_resp[%0d]: got rdata=%h err=%b want %h/%b", i, o.rdata, o.err, exp, addr >= DEPTH);
            end
        end
    endtask

    task automatic test_reset_mid();
        obs_t o;
        bit   seen = 1'b0;
        psel_a  = 1'b1;
        penable = 1'b0;
        pwrite  = 1'b0;
        paddr   = 32'd30;
        @(posedge clk); #1;
        penable = 1'b1;
        for (int i = 0; i < 16 && !seen; i++) begin
            @(negedge clk);
            seen = (pready_a === 1'b1);
        end
        checks++;
        if (!seen) begin errors++; $display("FAIL mid_reset_ready: pready never rose, want 1"); end
        prst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (pready_a !== 1'b0 || pslverr_a !== 1'b0 || prdata_a !== '0) begin
            errors++; $display("FAIL mid_reset_outputs: got %b/%b/%h want 0/0/0", pready_a, pslverr_a, prdata_a);
        end
        prst    = 1'b0;
        psel_a  = 1'b0;
        penable = 1'b0;
        model_clear();
        apb_xfer(1'b0, 1'b0, 32'd10, 32'h0, 1'b0, o);
        checks++;
        if (o.rdata !== 32'h0 || o.err !== 1'b0) begin
            errors++; $display("FAIL mid_reset_storage: got %h err=%b want 0/0", o.rdata, o.err);
        end
    endtask

    initial begin
        prst    = 1'b1;
        psel_a  = 1'b0;
        psel_b  = 1'b0;
        penable = 1'b0;
        pwrite  = 1'b0;
        paddr   = '0;
        pwdata  = '0;
        model_clear();
        test_reset();
        test_read_unwritten();
        test_ignore_penable();
        test_abort();
        test_write_read();
        test_back_to_back();
        test_out_of_range();
        test_fast();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/apb_slave_mem.md
APB_SLAVE_MEM -- requirements
Module: apb_slave_mem

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, PADDR width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, PWDATA/PRDATA width.
REQ-003 SHALL have parameter DEPTH, default 64, number of DATA_WIDTH-bit storage words.
REQ-004 SHALL have parameter WAIT_CYCLES, default 2, wait states inserted per transfer (0 allowed).
REQ-005 SHALL have port pclk_i  input  1  sole clock, all logic on rising edge.
REQ-006 SHALL have port prst_i  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port psel_i  input  1  slave select from APB master.
REQ-008 SHALL have port penable_i  input  1  access-phase strobe.
REQ-009 SHALL have port pwrite_i  input  1  1 = write, 0 = read.
REQ-010 SHALL have port paddr_i  input  ADDR_WIDTH  word address.
REQ-011 SHALL have port pwdata_i  input  DATA_WIDTH  write data.
REQ-012 SHALL have port pready_o  output  1  transfer completion, registered.
REQ-013 SHALL have port prdata_o  output  DATA_WIDTH  read data, registered.
REQ-014 SHALL have port pslverr_o  output  1  error response, registered.

Function
REQ-015 SHALL implement FSM states IDLE, WAIT, READY; pready_o = 1 only in READY.
REQ-016 IDLE: on an edge sampling psel_i=1 and penable_i=0 (setup phase), SHALL latch paddr_i, pwrite_i and pwdata_i, clear wait counter, and go to WAIT (or to READY directly if WAIT_CYCLES=0).
REQ-017 WAIT: counter SHALL increment each edge while psel_i=1 and penable_i=1; on the edge where counter = WAIT_CYCLES-1 SHALL go to READY.
REQ-018 Result: pready_o low for exactly WAIT_CYCLES access-phase cycles, then high for exactly one cycle.
REQ-019 Address is in range iff latched paddr < DEPTH; index = latched paddr (no wrap, no aliasing).
REQ-020 On the transition into READY, read + in range: prdata_o SHALL load mem[paddr]; pslverr_o SHALL be 0.
REQ-021 On the transition into READY, out of range (read or write): pslverr_o SHALL be 1 and prdata_o 0.
REQ-022 Write + in range: mem[paddr] SHALL update with latched pwdata on the READY-state edge sampling psel_i=1, penable_i=1; out-of-range writes SHALL change no storage.
REQ-023 On leaving READY SHALL go to IDLE and clear pready_o, pslverr_o and prdata_o to 0 on the same edge.
REQ-024 A write completed at edge E SHALL be visible to a read whose setup phase is sampled at E+1 or later.
REQ-025 If psel_i=0 is sampled in WAIT or READY (aborted transfer), SHALL return to IDLE, commit no write and clear outputs.
REQ-026 penable_i=1 sampled in IDLE without a preceding setup phase SHALL be ignored (remain IDLE, no response).
REQ-027 Back-to-back transfers: a setup phase sampled on the first edge after READY SHALL be accepted normally; no idle cycle is required.
REQ-028 pwrite_i, paddr_i and pwdata_i changes after setup latch SHALL NOT affect the ongoing transfer.

Reset
REQ-029 prst_i=1 at a rising edge SHALL force IDLE, counter 0, pready_o=0, pslverr_o=0, prdata_o=0, and all DEPTH words to 0.
REQ-030 Reset asserted in WAIT or READY SHALL abort the transfer; a pending write SHALL NOT commit.
REQ-031 Reset SHALL take priority over every other event in the same cycle.

Verification
REQ-032 Write 20 to addr 10, then read addr 10 -> pready_o low 2 access cycles then high 1 cycle; prdata_o=20, pslverr_o=0.
REQ-033 Writes (10,20),(20,40),(30,60) then reads 10,20,30 back-to-back -> prdata_o 20, 40, 60 in order, no dropped transfers.
REQ-034 Read addr 64 and write 0xDEAD to addr 100 -> pslverr_o=1 with pready_o, prdata_o=0; all storage unchanged.
REQ-035 WAIT_CYCLES=0 build: write then read addr 5 -> pready_o high in the first access cycle of each transfer.
REQ-036 Drop psel_i during WAIT of write to addr 3 -> IDLE, mem[3] stays 0; assert prst_i mid-transfer -> all outputs 0 next cycle.
REQ-037 Read addr 7 after reset with no prior write -> prdata_o=0, pslverr_o=0.
